// File: rtl/wb_dma_ch_dispatch.sv
// Grant consumer for the DMA channel arbiter: starts the engine on the granted channel,
// waits for done/error/watchdog, then returns a one-cycle advance so the arbiter rotates.
module wb_dma_ch_dispatch #(
    parameter int CH_COUNT  = 31,
    parameter int TO_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [30:0] req,
    input  logic [4:0]  gnt,
    input  logic        pause,
    input  logic        de_done,
    input  logic        de_err,
    output logic        de_start,
    output logic        de_abort,
    output logic [4:0]  de_ch,
    output logic [30:0] ch_ack,
    output logic [30:0] ch_err,
    output logic        advance,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0]  IDLE    = 2'd0;
    localparam logic [1:0]  BUSY    = 2'd1;
    localparam logic [1:0]  SETTLE  = 2'd2;
    localparam logic [5:0]  CH_LIM  = 6'(CH_COUNT);
    localparam logic [15:0] TO_LAST = 16'(TO_CYCLES - 1);
    localparam bit          TO_EN   = (TO_CYCLES != 0);

    logic [1:0]  r_state;
    logic [15:0] r_cnt;
    logic        r_de_start;
    logic        r_de_abort;
    logic [4:0]  r_de_ch;
    logic [30:0] r_ch_ack;
    logic [30:0] r_ch_err;
    logic        r_advance;
    logic        r_busy;

    logic [31:0] w_req_ext;
    logic        w_req_sel;
    logic        w_start;
    logic        w_timeout;
    logic [30:0] w_onehot;

    // Extra top bit keeps req indexable for gnt=31; the range check masks it anyway.
    assign w_req_ext = {1'b0, req};
    assign w_req_sel = w_req_ext[gnt];
    assign w_start   = !pause && ({1'b0, gnt} < CH_LIM) && w_req_sel;
    assign w_timeout = TO_EN && (r_cnt == TO_LAST);
    assign w_onehot  = 31'd1 << r_de_ch;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_de_start <= 1'b0;
            r_de_abort <= 1'b0;
            r_de_ch    <= '0;
            r_ch_ack   <= '0;
            r_ch_err   <= '0;
            r_advance  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_de_start <= 1'b0;
            r_de_abort <= 1'b0;
            r_ch_ack   <= '0;
            r_ch_err   <= '0;
            r_advance  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_de_ch    <= gnt;
                        r_de_start <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= BUSY;
                        r_busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (de_err) begin
                        r_ch_err  <= w_onehot;
                        r_advance <= 1'b1;
                        r_state   <= SETTLE;
                    end else if (de_done) begin
                        r_ch_ack  <= w_onehot;
                        r_advance <= 1'b1;
                        r_state   <= SETTLE;
                    end else if (w_timeout) begin
                        r_ch_err   <= w_onehot;
                        r_de_abort <= 1'b1;
                        r_advance  <= 1'b1;
                        r_state    <= SETTLE;
                    end
                end
                // One dead cycle so the arbiter's stale grant is never re-sampled.
                SETTLE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign de_start  = r_de_start;
    assign de_abort  = r_de_abort;
    assign de_ch     = r_de_ch;
    assign ch_ack    = r_ch_ack;
    assign ch_err    = r_ch_err;
    assign advance   = r_advance;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: doc/wb_dma_ch_dispatch.md
# wb_dma_ch_dispatch

Grant consumer for the DMA channel arbiter. It watches the arbiter's 5-bit grant, starts the DMA engine on the granted channel, and waits for completion, error or watchdog timeout. It then returns a one-cycle `advance` to the arbiter so the arbiter rotates to the next requester. It sits between `wb_dma_ch_arb` and the DMA engine, in the same clock domain.

## Interface
Parameters:
- `CH_COUNT`, default 31: number of implemented channels. Grants at or above this value are ignored.
- `TO_CYCLES`, default 1024: watchdog limit in BUSY cycles. 0 disables the watchdog. Maximum 65535; the counter is 16 bits.

Ports:
- `clk`  in  1  system clock; everything is sampled on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  31  channel request vector, the same vector that feeds the arbiter.
- `gnt`  in  5  arbiter grant, a channel index.
- `pause`  in  1  while high, no new channel is started.
- `de_done`  in  1  engine has finished the current channel.
- `de_err`  in  1  engine error on the current channel.
- `de_start`  out  1  one-cycle pulse: start the engine on `de_ch`.
- `de_abort`  out  1  one-cycle pulse: watchdog abort of the current channel.
- `de_ch`  out  5  latched channel under service.
- `ch_ack`  out  31  one-hot completion pulse, indexed by `de_ch`.
- `ch_err`  out  31  one-hot error/timeout pulse, indexed by `de_ch`.
- `advance`  out  1  one-cycle pulse to the arbiter.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
The block has three states: IDLE, BUSY and SETTLE. All outputs are registered.

IDLE
- Start condition: `!pause && gnt < CH_COUNT && req[gnt]`.
- When the start condition holds: latch `de_ch <= gnt`, pulse `de_start`, clear the watchdog counter, go to BUSY.
- Otherwise stay in IDLE. This covers `gnt` out of range and `req[gnt]==0`, for example while the arbiter is still rotating.

BUSY
- The watchdog counter increments every cycle in BUSY.
- `de_err`: pulse `ch_err[de_ch]` and `advance`, go to SETTLE.
- `de_done` without `de_err`: pulse `ch_ack[de_ch]` and `advance`, go to SETTLE.
- Timeout: `TO_CYCLES!=0`, counter `== TO_CYCLES-1`, and neither `de_done` nor `de_err` at that edge. Pulse `ch_err[de_ch]`, `de_abort` and `advance`, go to SETTLE.
- Priority when events coincide: `de_err` > `de_done` > timeout.
- `req[de_ch]` dropping during BUSY has no effect; the block still waits for `de_done`, `de_err` or timeout.
- `pause` has no effect in BUSY.

SETTLE
- Always exactly one cycle, then back to IDLE.
- Purpose: the arbiter updates its registered grant after `advance`, so the stale `gnt` is not re-sampled.

Other rules
- `de_done` and `de_err` are ignored in IDLE and in SETTLE.
- `ch_ack` and `ch_err` are never nonzero together, and each has at most one bit set.

## Timing
- Reset (async, `rst=0`): state=IDLE, counter=0. All outputs go to 0 immediately: `de_start`, `de_abort`, `de_ch=0`, `ch_ack=0`, `ch_err=0`, `advance`, `busy`.
- Reset mid-BUSY: no `advance` and no `ch_*` pulse is emitted. The arbiter is reset by the same `rst`.
- Start condition true at edge N: `de_start`=1, `de_ch` valid and `busy`=1 during cycle N+1.
- `de_done`/`de_err` sampled at edge M: `ch_ack`/`ch_err` and `advance` are high for cycle M+1 only, which is the SETTLE cycle.
- State is back in IDLE in cycle M+2. The earliest next `de_start` is in cycle M+3.
- `busy` is high from cycle N+1 through cycle M+1 inclusive.
- Watchdog with `de_start` in cycle N+1: the abort edge is N+`TO_CYCLES`. `de_abort`, `ch_err` and `advance` are high in cycle N+`TO_CYCLES`+1.
- `de_start`, `de_abort` and `advance` are never high for two consecutive cycles.

## Test plan
- Basic service:
  - Stimulus: `req=31'h8`, `gnt=3`, `pause=0`.
  - Required: `de_start` 1 cycle later with `de_ch=3`.
  - Then: `de_done` 5 cycles later gives `ch_ack=31'h8` and `advance` for 1 cycle, `busy` falls 2 cycles after `de_done`.
- Error priority:
  - Stimulus: `de_done=1` and `de_err=1` on the same edge, with `de_ch=7`.
  - Required: `ch_err=31'h80`, `ch_ack=0`, `advance`=1 for one cycle.
- Watchdog:
  - Stimulus: `TO_CYCLES=8`, no `de_done` after `de_start` on channel 12.
  - Required: `de_abort`, `ch_err=1<<12` and `advance` exactly 8 cycles after the `de_start` cycle.
  - Variant: with `TO_CYCLES=0` the block stays in BUSY for 1000 cycles.
- Gating:
  - `pause=1`, `req[gnt]=1`: no `de_start`.
  - `gnt=31`, `req[30:0]` all ones: no `de_start` (31 is out of range).
  - `req[gnt]=0` with other `req` bits set: no `de_start`.
  - Raising `pause` during BUSY does not block completion.
- Back-to-back channels:
  - Stimulus: `req=31'h5`, arbiter model moves `gnt` 0→2 one cycle after `advance`.
  - Required: second `de_start` with `de_ch=2` exactly 3 cycles after the first `de_done` edge; no start on stale `gnt=0`.
- Reset mid-operation:
  - Stimulus: `rst` low for 1 cycle during BUSY.
  - Required: all outputs go to 0 asynchronously, no `advance` pulse; after release, a normal start resumes.
